ambiente_robo: RTL and testbench
================================

AMBIENTE_ROBO -- requirements
Module: ambiente_robo

Interface
REQ-001 SHALL have parameter: MAX_STEPS, 1000, RUN-cycle budget before forced timeout.
REQ-002 SHALL have port: clock  in  1  single system clock, all state updates on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: map_we  in  1  map-cell write strobe, honoured only in LOAD.
REQ-005 SHALL have port: map_addr  in  6  cell address {y[2:0],x[2:0]}.
REQ-006 SHALL have port: map_data  in  2  cell type: 00 free, 01 wall, 10 barrier (removable), 11 exit.
REQ-007 SHALL have ports: start_x  in  3, start_y  in  3, start_dir  in  2  initial pose, sampled on start.
REQ-008 SHALL have port: start  in  1  LOAD->RUN request.
REQ-009 SHALL have ports: avancar, girar, remover  in  1 each  robot commands.
REQ-010 SHALL have ports: head, left, under, barrier  out  1 each  sensor signals returned to the robot.
REQ-011 SHALL have ports: pos_x  out  3, pos_y  out  3, dir  out  2  current pose.
REQ-012 SHALL have ports: running, done, timeout, cmd_error  out  1 each  status.
REQ-013 SHALL have ports: steps  out  16  RUN cycles elapsed; collisions  out  8  blocked-advance count.

Function
REQ-014 SHALL hold a 64-cell x 2-bit map; the cell at (x,y) is addressed {y,x}.
REQ-015 SHALL encode directions 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1); front cell = pose+dir, left cell = pose+((dir-1) mod 4).
REQ-016 SHALL treat any off-grid neighbour as a wall; off-grid coordinates SHALL never wrap.
REQ-017 SHALL drive the sensors combinationally from registered pose and map: head = front cell wall; left = left cell wall; barrier = front cell barrier; under = current cell exit.
REQ-018 SHALL implement FSM LOAD -> RUN -> DONE; reset enters LOAD.
REQ-019 LOAD: map_we=1 SHALL write map_data to map_addr at the edge; start=1 SHALL load pos/dir from start_* and enter RUN; if map_we and start are both high, the write SHALL complete and the transition SHALL also occur.
REQ-020 RUN: exactly one command SHALL be sampled per rising edge, and its effect SHALL be visible on the pose, map and sensors in the following cycle.
REQ-021 girar=1 alone: dir <= dir+1 mod 4 (clockwise), position unchanged.
REQ-022 avancar=1 alone: front cell free or exit -> pose moves one cell; front cell wall or barrier -> pose unchanged and collisions incremented, saturating at 255.
REQ-023 remover=1 alone: a barrier in the front cell SHALL be rewritten to free; any other cell type SHALL be left unchanged, with no error.
REQ-024 Two or more commands high together SHALL cause no pose/map change and SHALL set cmd_error, which is sticky until reset.
REQ-025 No command high SHALL be legal and SHALL leave the pose unchanged.
REQ-026 steps SHALL increment on every RUN cycle, saturating at 65535.
REQ-027 The environment SHALL enter DONE at the edge after the pose lands on an exit cell (under=1); starting on an exit SHALL enter DONE on the first RUN edge.
REQ-028 When steps reaches MAX_STEPS in RUN, the FSM SHALL enter DONE and set timeout=1; if the exit is reached on the same edge, the exit SHALL win and timeout SHALL stay 0.
REQ-029 DONE SHALL ignore all commands, map_we and start; pose, counters and sensors SHALL hold.
REQ-030 running SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-031 map_we outside LOAD SHALL be ignored.

Reset
REQ-032 Reset SHALL set state LOAD, all 64 cells free, pos_x=pos_y=0, dir=0, steps=0, collisions=0, and done, timeout, cmd_error, running all 0.
REQ-033 Reset SHALL take priority over every other input in any state, including mid-RUN, and SHALL discard that cycle's command.
REQ-034 After reset the sensors SHALL reflect the cleared map: head=1 (off-grid north at y=0), left=1 (off-grid west at x=0), under=0, barrier=0.

Verification
REQ-035 Load (3,0)=wall; start at (2,0), dir E; then girar x1 -> dir=2; avancar -> pos (2,1); sensors head=0, left=0.
REQ-036 Load (3,2)=barrier; start at (2,2), dir E -> barrier=1; avancar -> collisions=1, pos unchanged; remover -> barrier=0; avancar -> pos (3,2).
REQ-037 Load (1,0)=exit; start at (0,0), dir E; avancar -> next cycle under=1, then done=1, and later commands leave the pose unchanged.
REQ-038 In RUN, drive avancar and girar together -> cmd_error=1, pose unchanged; a later legal girar still rotates the robot, and cmd_error stays 1.
REQ-039 With MAX_STEPS=10 and no exit on the map, hold girar -> done=1, timeout=1, steps=10.
REQ-040 Assert reset mid-RUN after 3 moves -> next cycle state LOAD, pose (0,0) dir 0, map cleared, counters 0.

Source files
------------

// File: rtl/ambiente_robo.sv
// ambiente_robo: grid-world environment for a simple robot controller.
// Holds an 8x8 map of 2-bit cells, tracks the robot pose, answers its
// sensor queries combinationally and applies one command per clock edge.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   map_we, map_addr,         map-cell write port ({y,x} address),
//   map_data                  only accepted while loading
//   start_x, start_y,         initial pose, sampled together with start
//   start_dir, start
//   avancar, girar, remover   robot commands: advance, rotate clockwise,
//                             remove barrier
//   head, left, under,        sensors: wall ahead, wall to the left,
//   barrier                   standing on exit, barrier ahead
//   pos_x, pos_y, dir         current pose
//   running, done, timeout,   status flags
//   cmd_error
//   steps, collisions         RUN-cycle counter, blocked-advance counter
module ambiente_robo #(
  parameter int MAX_STEPS = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        map_we,
  input  logic [5:0]  map_addr,
  input  logic [1:0]  map_data,
  input  logic [2:0]  start_x,
  input  logic [2:0]  start_y,
  input  logic [1:0]  start_dir,
  input  logic        start,
  input  logic        avancar,
  input  logic        girar,
  input  logic        remover,
  output logic        head,
  output logic        left,
  output logic        under,
  output logic        barrier,
  output logic [2:0]  pos_x,
  output logic [2:0]  pos_y,
  output logic [1:0]  dir,
  output logic        running,
  output logic        done,
  output logic        timeout,
  output logic        cmd_error,
  output logic [15:0] steps,
  output logic [7:0]  collisions
);

  localparam logic [1:0]  CELL_FREE    = 2'b00;
  localparam logic [1:0]  CELL_WALL    = 2'b01;
  localparam logic [1:0]  CELL_BARRIER = 2'b10;
  localparam logic [1:0]  CELL_EXIT    = 2'b11;
  localparam logic [15:0] STEP_LIMIT   = 16'(MAX_STEPS);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state, next_state;

  logic [1:0]  map_mem [0:63];

  logic [6:0]  front_nb, left_nb;
  logic [1:0]  front_type, left_type, here_type;

  logic [2:0]  next_x, next_y;
  logic [1:0]  next_dir;
  logic [15:0] next_steps;
  logic [7:0]  next_coll;
  logic        next_timeout, next_err;
  logic        map_wr_en;
  logic [5:0]  map_wr_addr;
  logic [1:0]  map_wr_data;
  logic [1:0]  cmd_count;
  logic        landing;

  // Neighbour of (x,y) in direction d, packed as {on_grid, y, x}.
  // Off-grid neighbours are flagged rather than wrapped.
  function automatic logic [6:0] neighbour(input logic [2:0] x,
                                           input logic [2:0] y,
                                           input logic [1:0] d);
    logic       ok;
    logic [2:0] nx, ny;
    ok = 1'b1;
    nx = x;
    ny = y;
    case (d)
      2'd0: begin ok = (y != 3'd0); ny = y - 3'd1; end
      2'd1: begin ok = (x != 3'd7); nx = x + 3'd1; end
      2'd2: begin ok = (y != 3'd7); ny = y + 3'd1; end
      default: begin ok = (x != 3'd0); nx = x - 3'd1; end
    endcase
    return {ok, ny, nx};
  endfunction

  // Sensors look at the registered pose and map only; anything off the
  // grid reads as a wall.
  always_comb begin
    front_nb   = neighbour(pos_x, pos_y, dir);
    left_nb    = neighbour(pos_x, pos_y, dir - 2'd1);
    front_type = front_nb[6] ? map_mem[front_nb[5:0]] : CELL_WALL;
    left_type  = left_nb[6]  ? map_mem[left_nb[5:0]]  : CELL_WALL;
    here_type  = map_mem[{pos_y, pos_x}];
    head       = (front_type == CELL_WALL);
    left       = (left_type == CELL_WALL);
    barrier    = (front_type == CELL_BARRIER);
    under      = (here_type == CELL_EXIT);
  end

  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);

  // Next-state and datapath decisions. A robot already standing on the
  // exit finishes without its command taking effect, so the final pose is
  // always the exit cell. An advance that lands on the exit on the same
  // edge the step budget runs out counts as a success, not a timeout.
  always_comb begin
    next_state   = state;
    next_x       = pos_x;
    next_y       = pos_y;
    next_dir     = dir;
    next_steps   = steps;
    next_coll    = collisions;
    next_timeout = timeout;
    next_err     = cmd_error;
    map_wr_en    = 1'b0;
    map_wr_addr  = map_addr;
    map_wr_data  = map_data;
    landing      = 1'b0;
    cmd_count    = {1'b0, avancar} + {1'b0, girar} + {1'b0, remover};

    case (state)
      ST_LOAD: begin
        map_wr_en = map_we;
        if (start) begin
          next_x     = start_x;
          next_y     = start_y;
          next_dir   = start_dir;
          next_state = ST_RUN;
        end
      end

      ST_RUN: begin
        next_steps = (steps == 16'hFFFF) ? steps : steps + 16'd1;
        if (under) begin
          next_state = ST_DONE;
        end else begin
          if (cmd_count > 2'd1) begin
            next_err = 1'b1;
          end else if (girar) begin
            next_dir = dir + 2'd1;
          end else if (avancar) begin
            if (front_type == CELL_FREE || front_type == CELL_EXIT) begin
              next_x  = front_nb[2:0];
              next_y  = front_nb[5:3];
              landing = (front_type == CELL_EXIT);
            end else begin
              next_coll = (collisions == 8'hFF) ? collisions : collisions + 8'd1;
            end
          end else if (remover) begin
            if (front_type == CELL_BARRIER) begin
              map_wr_en   = 1'b1;
              map_wr_addr = front_nb[5:0];
              map_wr_data = CELL_FREE;
            end
          end
          if (next_steps >= STEP_LIMIT) begin
            next_state   = ST_DONE;
            next_timeout = !landing;
          end
        end
      end

      default: begin
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_LOAD;
    else       state <= next_state;
  end

  // Pose, counters and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x      <= 3'd0;
      pos_y      <= 3'd0;
      dir        <= 2'd0;
      steps      <= 16'd0;
      collisions <= 8'd0;
      timeout    <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      pos_x      <= next_x;
      pos_y      <= next_y;
      dir        <= next_dir;
      steps      <= next_steps;
      collisions <= next_coll;
      timeout    <= next_timeout;
      cmd_error  <= next_err;
    end
  end

  // Map storage; reset clears every cell to free.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) map_mem[i] <= CELL_FREE;
    end else if (map_wr_en) begin
      map_mem[map_wr_addr] <= map_wr_data;
    end
  end

endmodule

// File: tb/tb_ambiente_robo.sv
// tb_ambiente_robo: directed self-checking bench for ambiente_robo.
// Uses MAX_STEPS=10 so the step-budget cases are reachable quickly.
module tb_ambiente_robo;

  logic        clock;
  logic        reset;
  logic        map_we;
  logic [5:0]  map_addr;
  logic [1:0]  map_data;
  logic [2:0]  start_x, start_y;
  logic [1:0]  start_dir;
  logic        start;
  logic        avancar, girar, remover;
  logic        head, left, under, barrier;
  logic [2:0]  pos_x, pos_y;
  logic [1:0]  dir;
  logic        running, done, timeout, cmd_error;
  logic [15:0] steps;
  logic [7:0]  collisions;

  int passed = 0;
  int total  = 0;

  ambiente_robo #(.MAX_STEPS(10)) dut (
    .clock(clock), .reset(reset),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .start_x(start_x), .start_y(start_y), .start_dir(start_dir),
    .start(start),
    .avancar(avancar), .girar(girar), .remover(remover),
    .head(head), .left(left), .under(under), .barrier(barrier),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
    .running(running), .done(done), .timeout(timeout), .cmd_error(cmd_error),
    .steps(steps), .collisions(collisions)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic g, input logic r);
    avancar = a;
    girar   = g;
    remover = r;
    tick();
    avancar = 1'b0;
    girar   = 1'b0;
    remover = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_cell(input logic [2:0] x, input logic [2:0] y,
                           input logic [1:0] t);
    map_we   = 1'b1;
    map_addr = {y, x};
    map_data = t;
    tick();
    map_we   = 1'b0;
  endtask

  task automatic start_at(input logic [2:0] x, input logic [2:0] y,
                          input logic [1:0] d);
    start_x   = x;
    start_y   = y;
    start_dir = d;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic check_pose(input string tag, input logic [2:0] x,
                            input logic [2:0] y, input logic [1:0] d);
    check_output({tag, "_x"},   16'(pos_x), 16'(x));
    check_output({tag, "_y"},   16'(pos_y), 16'(y));
    check_output({tag, "_dir"}, 16'(dir),   16'(d));
  endtask

  initial begin
    reset = 1'b0; map_we = 1'b0; map_addr = 6'd0; map_data = 2'd0;
    start_x = 3'd0; start_y = 3'd0; start_dir = 2'd0; start = 1'b0;
    avancar = 1'b0; girar = 1'b0; remover = 1'b0;

    // Reset state and sensors on the cleared map.
    do_reset();
    check_pose("rst", 3'd0, 3'd0, 2'd0);
    check_output("rst_running", 16'(running),   16'd0);
    check_output("rst_done",    16'(done),      16'd0);
    check_output("rst_timeout", 16'(timeout),   16'd0);
    check_output("rst_err",     16'(cmd_error), 16'd0);
    check_output("rst_steps",   steps,          16'd0);
    check_output("rst_coll",    16'(collisions), 16'd0);
    check_output("rst_head",    16'(head),      16'd1);
    check_output("rst_left",    16'(left),      16'd1);
    check_output("rst_under",   16'(under),     16'd0);
    check_output("rst_barrier", 16'(barrier),   16'd0);

    // Wall ahead, rotate, advance south.
    load_cell(3'd3, 3'd0, 2'b01);
    start_at(3'd2, 3'd0, 2'd1);
    check_output("a_running", 16'(running), 16'd1);
    check_output("a_head_wall", 16'(head),  16'd1);
    check_output("a_left_edge", 16'(left),  16'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_pose("a_turn", 3'd2, 3'd0, 2'd2);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_pose("a_move", 3'd2, 3'd1, 2'd2);
    check_output("a_head", 16'(head),  16'd0);
    check_output("a_left", 16'(left),  16'd0);
    check_output("a_steps", steps,     16'd2);

    // Barrier: collide, remove, pass.
    do_reset();
    load_cell(3'd3, 3'd2, 2'b10);
    start_at(3'd2, 3'd2, 2'd1);
    check_output("b_barrier", 16'(barrier), 16'd1);
    check_output("b_head",    16'(head),    16'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("b_coll", 16'(collisions), 16'd1);
    check_pose("b_blocked", 3'd2, 3'd2, 2'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("b_removed", 16'(barrier), 16'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_pose("b_pass", 3'd3, 3'd2, 2'd1);
    check_output("b_coll_hold", 16'(collisions), 16'd1);

    // Exit reached, then DONE ignores everything.
    do_reset();
    load_cell(3'd1, 3'd0, 2'b11);
    start_at(3'd0, 3'd0, 2'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("c_under", 16'(under), 16'd1);
    check_output("c_not_done", 16'(done), 16'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("c_done", 16'(done), 16'd1);
    check_output("c_running", 16'(running), 16'd0);
    check_output("c_timeout", 16'(timeout), 16'd0);
    check_pose("c_exit", 3'd1, 3'd0, 2'd1);
    check_output("c_steps", steps, 16'd2);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    load_cell(3'd2, 3'd0, 2'b01);
    start_at(3'd5, 3'd5, 2'd3);
    check_pose("c_hold", 3'd1, 3'd0, 2'd1);
    check_output("c_head_hold", 16'(head), 16'd0);
    check_output("c_steps_hold", steps, 16'd2);
    check_output("c_done_hold", 16'(done), 16'd1);

    // Illegal command combination; map_we ignored in RUN.
    do_reset();
    start_at(3'd3, 3'd3, 2'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("d_err", 16'(cmd_error), 16'd1);
    check_pose("d_nochange", 3'd3, 3'd3, 2'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_pose("d_turn", 3'd3, 3'd3, 2'd1);
    check_output("d_err_sticky", 16'(cmd_error), 16'd1);
    load_cell(3'd4, 3'd3, 2'b01);
    check_output("d_we_ignored", 16'(head), 16'd0);

    // Step budget runs out.
    do_reset();
    start_at(3'd4, 3'd4, 2'd0);
    girar = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check_output("e_steps9", steps, 16'd9);
    check_output("e_run9", 16'(running), 16'd1);
    tick();
    check_output("e_done", 16'(done), 16'd1);
    check_output("e_timeout", 16'(timeout), 16'd1);
    check_output("e_steps10", steps, 16'd10);
    check_output("e_dir", 16'(dir), 16'd2);
    tick();
    tick();
    girar = 1'b0;
    check_output("e_steps_hold", steps, 16'd10);
    check_output("e_dir_hold", 16'(dir), 16'd2);

    // Exit landing on the same edge as the budget: exit wins.
    do_reset();
    load_cell(3'd1, 3'd1, 2'b11);
    start_at(3'd0, 3'd1, 2'd1);
    for (int i = 0; i < 9; i++) tick();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("f_done", 16'(done), 16'd1);
    check_output("f_timeout", 16'(timeout), 16'd0);
    check_pose("f_exit", 3'd1, 3'd1, 2'd1);

    // Simultaneous write+start, then reset mid-RUN with a command.
    do_reset();
    map_we   = 1'b1;
    map_addr = {3'd0, 3'd1};
    map_data = 2'b10;
    start_at(3'd0, 3'd0, 2'd1);
    map_we   = 1'b0;
    check_output("g_running", 16'(running), 16'd1);
    check_output("g_barrier", 16'(barrier), 16'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
    check_pose("g_moved", 3'd0, 3'd3, 2'd2);
    reset   = 1'b1;
    avancar = 1'b1;
    tick();
    reset   = 1'b0;
    avancar = 1'b0;
    check_pose("g_rst", 3'd0, 3'd0, 2'd0);
    check_output("g_rst_running", 16'(running), 16'd0);
    check_output("g_rst_steps", steps, 16'd0);
    check_output("g_rst_coll", 16'(collisions), 16'd0);
    start_at(3'd0, 3'd0, 2'd1);
    check_output("g_map_clear", 16'(barrier), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
